// File: rtl/spi_sensor_pkg.sv
// Shared definitions for the SPI sensor responder: command opcodes, FSM states
// and the read-only ID byte table that lives at the top of the register space.
package spi_sensor_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  localparam logic [1:0] OP_CONVERT = 2'b00;
  localparam logic [1:0] OP_CAL     = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Constant ID bytes: "INTAN" at 40..44, "RHD2132" at 45..51, revision at 63.
  function automatic logic [7:0] id_byte(input logic [ADDR_W-1:0] addr);
    logic [7:0] val;
    case (addr)
      6'd40:   val = 8'h49;
      6'd41:   val = 8'h4E;
      6'd42:   val = 8'h54;
      6'd43:   val = 8'h41;
      6'd44:   val = 8'h4E;
      6'd45:   val = 8'h52;
      6'd46:   val = 8'h48;
      6'd47:   val = 8'h44;
      6'd48:   val = 8'h32;
      6'd49:   val = 8'h31;
      6'd50:   val = 8'h33;
      6'd51:   val = 8'h32;
      6'd63:   val = 8'h01;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/spi_sensor_responder_edge_sync.sv
// Oversampling front end: synchronizes SCLK, CS_b and MOSI into the clk domain
// and produces single-cycle edge strobes from the synchronized levels.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_in,
  input  logic cs_b_in,
  input  logic mosi_in,
  output logic cs_b_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_b_fall
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_edge_sync needs at least two synchronizer stages");
  end

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_b_in};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
  end

  // The CS_b chain comes out of reset at its deasserted level so that
  // releasing reset with the link idle does not look like a select edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign cs_b_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
  assign cs_b_fall = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;

endmodule

// File: rtl/spi_sensor_responder.sv
// SPI mode-0 target modelling the sensor end of the link: decodes 16-bit
// commands and returns each result two frames later through a two-slot pipeline.
module spi_sensor_responder
  import spi_sensor_pkg::*;
#(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int N_REGS      = 64,
  parameter int RO_BASE     = 40,
  parameter int CAL_CYCLES  = 600
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              CS_b,
  input  logic              MOSI,
  output logic              MISO,
  output logic [ADDR_W-1:0] adc_chan,
  output logic              adc_req,
  input  logic [DATA_W-1:0] adc_data,
  output logic              cal_busy,
  output logic              frame_done,
  output logic              frame_err
);

  if (FRAME_BITS != DATA_W) begin : g_bad_frame
    $error("FRAME_BITS is fixed at 16 by the sensor protocol");
  end
  if ((N_REGS != (1 << ADDR_W)) || (RO_BASE < 1) || (RO_BASE > N_REGS)) begin : g_bad_regs
    $error("register space must be 64 entries with RO_BASE inside it");
  end

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int CAL_W = $clog2(CAL_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS);
  localparam logic [CAL_W-1:0]  CAL_LOAD = CAL_W'(CAL_CYCLES);
  localparam logic [ADDR_W-1:0] RO_ADDR  = ADDR_W'(RO_BASE);

  logic cs_b_s, mosi_s, sclk_rise, sclk_fall, cs_b_fall;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sclk_in  (SCLK),
    .cs_b_in  (CS_b),
    .mosi_in  (MOSI),
    .cs_b_s   (cs_b_s),
    .mosi_s   (mosi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_b_fall(cs_b_fall)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]     slot1_q, slot1_d;
  logic [DATA_W-1:0]     slot2_q, slot2_d;
  logic [7:0]            regs_q [RO_BASE];
  logic [7:0]            regs_d [RO_BASE];
  logic [CAL_W-1:0]      cal_cnt_q, cal_cnt_d;
  logic [ADDR_W-1:0]     adc_chan_q, adc_chan_d;
  logic                  adc_req_q, adc_req_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;
  logic                  conv_pend_q, conv_pend_d;
  logic                  conv_cap_q, conv_cap_d;

  logic [1:0]            opcode;
  logic [ADDR_W-1:0]     addr;
  logic [7:0]            wdata;
  logic [7:0]            rd_byte;
  logic                  addr_writable;

  always_comb begin
    opcode        = rx_shift_q[15:14];
    addr          = rx_shift_q[13:8];
    wdata         = rx_shift_q[7:0];
    addr_writable = (addr < RO_ADDR);
    rd_byte       = addr_writable ? regs_q[addr] : id_byte(addr);
  end

  // The frame is decoded on the SHIFT->DONE transition. A CONVERT's sample
  // arrives one cycle after adc_req, so slot 1 is patched two cycles later.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    slot1_d      = slot1_q;
    slot2_d      = slot2_q;
    regs_d       = regs_q;
    cal_cnt_d    = (cal_cnt_q != '0) ? cal_cnt_q - 1'b1 : cal_cnt_q;
    adc_chan_d   = adc_chan_q;
    adc_req_d    = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    conv_pend_d  = 1'b0;
    conv_cap_d   = conv_pend_q;

    if (conv_cap_q) begin
      slot1_d = adc_data;
    end

    case (state_q)
      IDLE: begin
        if (cs_b_fall) begin
          state_d    = SHIFT;
          tx_shift_d = slot2_q;
          bit_cnt_d  = '0;
        end
      end

      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
          slot2_d      = slot1_q;
          case (opcode)
            OP_CONVERT: begin
              adc_chan_d  = addr;
              adc_req_d   = 1'b1;
              conv_pend_d = ~cal_busy;
              slot1_d     = '0;
            end
            OP_CAL: begin
              cal_cnt_d = CAL_LOAD;
              slot1_d   = '0;
            end
            OP_WRITE: begin
              if (addr_writable) begin
                regs_d[addr] = wdata;
                slot1_d      = {8'hFF, wdata};
              end else begin
                slot1_d = {8'hFF, id_byte(addr)};
              end
            end
            OP_READ: begin
              slot1_d = {8'h00, rd_byte};
            end
          endcase
        end else if (cs_b_s) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
          if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end

      DONE: begin
        if (cs_b_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      slot1_q      <= '0;
      slot2_q      <= '0;
      cal_cnt_q    <= '0;
      adc_chan_q   <= '0;
      adc_req_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      conv_pend_q  <= 1'b0;
      conv_cap_q   <= 1'b0;
      for (int i = 0; i < RO_BASE; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      slot1_q      <= slot1_d;
      slot2_q      <= slot2_d;
      cal_cnt_q    <= cal_cnt_d;
      adc_chan_q   <= adc_chan_d;
      adc_req_q    <= adc_req_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      conv_pend_q  <= conv_pend_d;
      conv_cap_q   <= conv_cap_d;
      regs_q       <= regs_d;
    end
  end

  assign MISO       = ((state_q == SHIFT) && !cs_b_s) ? tx_shift_q[FRAME_BITS-1] : 1'b0;
  assign adc_chan   = adc_chan_q;
  assign adc_req    = adc_req_q;
  assign cal_busy   = (cal_cnt_q != '0);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/spi_sensor_responder.md
Name: spi_sensor_responder

Overview:
- Behavioural-synthesizable SPI target that models the sensor end of the link driven by the sensor interface master (MOSI_to_sensor, MISO_from_sensor, SCLK_wire, CS_b_wire).
- Receives 16-bit command frames, MSB first, and decodes them as CONVERT, CALIBRATE, WRITE or READ.
- Returns each command's result on MISO two frames later, matching the sensor's pipelined protocol.
- Runs on the system clock and oversamples SCLK/CS_b. Used in sim benches and for FPGA loopback of the master.

Parameters:
- FRAME_BITS, 16, bits per frame; fixed by protocol, checked at elaboration.
- SYNC_STAGES, 2, synchronizer depth on SCLK, CS_b, MOSI.
- N_REGS, 64, register-space size; 6-bit address.
- RO_BASE, 40, first read-only register; regs RO_BASE..63 hold constant ID bytes.
- CAL_CYCLES, 600, length of the clk-cycle busy window after CALIBRATE.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from master; idle low (mode 0).
- CS_b  in  1  chip select, active low.
- MOSI  in  1  serial command data.
- MISO  out  1  serial response data.
- adc_chan  out  6  channel of the most recent CONVERT.
- adc_req  out  1  one-cycle pulse requesting a sample for adc_chan.
- adc_data  in  16  sample; valid on the cycle after adc_req.
- cal_busy  out  1  high during the calibration window.
- frame_done  out  1  one-cycle pulse per complete 16-bit frame.
- frame_err  out  1  one-cycle pulse when a frame aborts short.

Behaviour:
- Reset (reset=0) clears synchronizers, shift registers, both pipeline slots, bit counter, cal counter and writable registers, and sets the ID constants.
  - Reset values: MISO=0, adc_chan=0, adc_req=0, cal_busy=0, frame_done=0, frame_err=0.
  - Reset mid-frame discards the frame with no pulses.
- Inputs pass through SYNC_STAGES flops. Edge detect runs on the synchronized signals.
  - Master must hold SCLK high and low for at least SYNC_STAGES+2 clk each.
- FSM states:
  - IDLE: on CS_b falling, go to SHIFT. Load tx_shift from pipe slot 2 and drive its MSB on MISO. Clear bit_cnt.
  - SHIFT: on SCLK rise, sample MOSI into rx_shift LSB and increment bit_cnt. On SCLK fall, shift tx_shift and present the next bit.
    - At bit_cnt=16, go to DONE.
    - On CS_b rise with bit_cnt<16, pulse frame_err, go to IDLE, and leave the pipeline unchanged.
  - DONE: decode rx_shift. Push the result into slot 1 and move slot 1 to slot 2. Pulse frame_done.
    - Wait for CS_b rise, then go to IDLE.
    - Extra SCLK edges in DONE are ignored. MISO holds 0.
- Decode, on rx[15:14]:
  - 00 CONVERT ch=rx[13:8]: set adc_chan=ch and pulse adc_req. Result = adc_data captured on the next cycle, or 16'h0000 if cal_busy.
  - 01 CALIBRATE: load the cal counter with CAL_CYCLES and raise cal_busy. Result 16'h0000.
    - A CALIBRATE during cal_busy reloads the counter.
  - 10 WRITE a=rx[13:8], d=rx[7:0]: write reg[a]=d if a<RO_BASE. Result {8'hFF, reg[a]} read after the write.
    - If a≥RO_BASE, the write is ignored and the result returns the constant.
  - 11 READ a=rx[13:8]: result {8'h00, reg[a]}.
- Pipeline: the result of frame N is shifted out during frame N+2.
  - The first two frames after reset return 16'h0000.
- cal_busy drops on the cycle the counter reaches 0. Cal counting continues regardless of SPI activity.
- MISO=0 whenever CS_b (synchronized) is high.

Decomposition:
- Shared package spi_sensor_pkg holds:
  - Opcode localparams: OP_CONVERT=2'b00, OP_CAL=2'b01, OP_WRITE=2'b10, OP_READ=2'b11.
  - FSM state encoding: IDLE, SHIFT, DONE.
  - ID constant table for registers 40..63 (e.g. reg40..44 = "INTAN" ASCII).
- One natural sub-module: spi_edge_sync. It holds the SYNC_STAGES synchronizer and rise/fall detect for SCLK, CS_b and MOSI, and is reused by the master's loopback bench.

Test Plan:
- After reset, send three frames: READ 40, READ 41, READ 0 (16'hE800, 16'hE900, 16'hC000). MISO returns 0x0000, 0x0000, then 0x0049.
- Send WRITE a=5 d=0xA5 (16'h85A5), then two READ 5 frames. The third frame's MISO is 0xFFA5; a following frame returns 0x00A5.
- Send WRITE a=45 d=0x12. reg45 is unchanged. The response two frames later is {8'hFF, ID[45]}.
- Send CONVERT ch=7 (16'h0700) with adc_data=16'h1234. adc_chan=7 and adc_req pulses once. Frame N+2 MISO returns 0x1234.
- Send CALIBRATE. cal_busy stays high exactly 600 clk. A CONVERT issued during that window returns 0x0000.
- Raise CS_b after 9 SCLK rises. frame_err pulses, frame_done does not, and the next full frame returns the slot that was pending before the abort.
